// File: rtl/fetch_unit.sv
// RV32I fetch: owns the fetch PC, issues in-order word requests, buffers words+PCs in a FIFO, drops wrong-path responses.
// Latency: accept in t, response in t+1, o_inst_vld in t+2. Backpressure: credit-limited requests; decode stalls the FIFO head.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_vld,
  input  logic        i_imem_req_rdy,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_vld,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_inst_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem   [FIFO_DEPTH];

  logic          w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [31:0]   w_redirect_pc;

  // Words in flight plus words buffered never exceed the FIFO, so a response always has a slot.
  assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_W;
  assign o_imem_req_vld = !i_reset && !i_redirect && w_credit;
  assign o_imem_addr    = r_fetch_pc;
  assign w_issue        = o_imem_req_vld && i_imem_req_rdy;
  assign w_out_next     = r_outstanding + CW'(w_issue) - CW'(i_imem_rsp_vld);
  assign w_push         = i_imem_rsp_vld && !i_redirect && (r_discard == '0);
  assign w_drop         = i_imem_rsp_vld && !i_redirect && (r_discard != '0);
  assign w_redirect_pc  = {i_redirect_pc[31:2], 2'b00};

  assign o_inst_vld = (r_count != '0);
  assign w_pop      = o_inst_vld && i_inst_rdy;
  assign o_inst     = o_inst_vld ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign o_inst_pc  = o_inst_vld ? r_pc_mem[r_rd_ptr]   : 32'h0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_discard  <= w_out_next;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop)  r_discard  <= r_discard - CW'(1);
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= i_imem_rsp_data;
      r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  a_discard_le_outstanding: assert property (@(posedge i_clk) disable iff (i_reset)
    r_outstanding >= r_discard);
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    ({1'b0, r_outstanding} + {1'b0, r_count}) <= DEPTH_W);
  a_no_rsp_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
    i_imem_rsp_vld |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with 1-cycle responses and a PC scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        i_reset;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_vld;
  logic        i_imem_req_rdy;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_vld;
  logic [31:0] i_imem_rsp_data;
  logic        o_inst_vld;
  logic        i_inst_rdy;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pops = 0;
  logic        rsp_en;
  logic [31:0] model_pc;
  logic [31:0] a0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc),
    .o_imem_req_vld (o_imem_req_vld),
    .i_imem_req_rdy (i_imem_req_rdy),
    .o_imem_addr    (o_imem_addr),
    .i_imem_rsp_vld (i_imem_rsp_vld),
    .i_imem_rsp_data(i_imem_rsp_data),
    .o_inst_vld     (o_inst_vld),
    .i_inst_rdy     (i_inst_rdy),
    .o_inst         (o_inst),
    .o_inst_pc      (o_inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sample on the falling edge, then drive the memory response just after the rising edge.
  task automatic run_cycle();
    logic [31:0] e;
    logic [31:0] a;
    @(negedge clk);
    if (i_reset) begin
      exp_q.delete();
      pend_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (o_inst_vld && i_inst_rdy && !i_redirect) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", o_inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", o_inst_pc, e);
          check("inst_word", o_inst, mem_word(e));
        end
      end
      if (i_redirect) begin
        exp_q.delete();
        model_pc = {i_redirect_pc[31:2], 2'b00};
      end
      if (o_imem_req_vld && i_imem_req_rdy) begin
        check("req_addr", o_imem_addr, model_pc);
        pend_q.push_back(o_imem_addr);
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (rsp_en && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      i_imem_rsp_vld  = 1'b1;
      i_imem_rsp_data = mem_word(a);
    end else begin
      i_imem_rsp_vld  = 1'b0;
      i_imem_rsp_data = 32'h0;
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_req_rdy = 1'b1;
    i_imem_rsp_vld = 1'b0;
    i_imem_rsp_data = 32'h0;
    i_inst_rdy = 1'b1;
    rsp_en = 1'b1;
    model_pc = RESET_PC;

    // Reset held for three cycles
    repeat (3) run_cycle();
    check("rst_inst_vld", 32'(o_inst_vld), 32'd0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_inst_pc", o_inst_pc, 32'h0);
    check("rst_req_vld", 32'(o_imem_req_vld), 32'd0);
    i_reset = 1'b0;
    #1;
    check("first_req_vld", 32'(o_imem_req_vld), 32'd1);
    check("first_req_addr", o_imem_addr, RESET_PC);

    // Streaming: first word visible two cycles after the first accept, then no bubbles
    check("lat_c0", 32'(o_inst_vld), 32'd0);
    run_cycle();
    check("lat_c1", 32'(o_inst_vld), 32'd0);
    run_cycle();
    check("lat_c2_vld", 32'(o_inst_vld), 32'd1);
    check("lat_c2_pc", o_inst_pc, RESET_PC);
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      check("stream_vld", 32'(o_inst_vld), 32'd1);
    end

    // Decode stall fills the FIFO and throttles requests
    i_inst_rdy = 1'b0;
    repeat (8) run_cycle();
    check("full_req_vld", 32'(o_imem_req_vld), 32'd0);
    check("full_inst_vld", 32'(o_inst_vld), 32'd1);
    check("full_buffered", 32'(exp_q.size()), 32'd4);
    i_inst_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      check("resume_vld", 32'(o_inst_vld), 32'd1);
    end

    // Memory stall: address held, no duplicate or skipped request
    i_imem_req_rdy = 1'b0;
    #1;
    check("stall_req_vld", 32'(o_imem_req_vld), 32'd1);
    check("stall_addr0", o_imem_addr, model_pc);
    a0 = o_imem_addr;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("stall_addr", o_imem_addr, a0);
    end
    i_imem_req_rdy = 1'b1;
    repeat (6) run_cycle();

    // Redirect with two words in flight, one returning in the redirect cycle
    i_imem_req_rdy = 1'b0;
    repeat (6) run_cycle();
    check("drain_vld", 32'(o_inst_vld), 32'd0);
    i_imem_req_rdy = 1'b1;
    rsp_en = 1'b0;
    run_cycle();
    run_cycle();
    i_imem_req_rdy = 1'b0;
    rsp_en = 1'b1;
    run_cycle();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0103;
    #1;
    check("redir_no_req", 32'(o_imem_req_vld), 32'd0);
    run_cycle();
    i_redirect = 1'b0;
    i_imem_req_rdy = 1'b1;
    check("redir_flush", 32'(o_inst_vld), 32'd0);
    run_cycle();
    check("redir_gap", 32'(o_inst_vld), 32'd0);
    run_cycle();
    check("redir_vld", 32'(o_inst_vld), 32'd1);
    check("redir_pc0", o_inst_pc, 32'h0000_0100);
    run_cycle();
    check("redir_pc1", o_inst_pc, 32'h0000_0104);

    // Back-to-back redirects: the later target wins
    repeat (4) run_cycle();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    run_cycle();
    i_redirect_pc = 32'h0000_0300;
    run_cycle();
    i_redirect = 1'b0;
    run_cycle();
    run_cycle();
    check("b2b_vld", 32'(o_inst_vld), 32'd1);
    check("b2b_pc", o_inst_pc, 32'h0000_0300);
    repeat (6) run_cycle();

    // Reset with a full FIFO
    i_inst_rdy = 1'b0;
    repeat (8) run_cycle();
    check("pre_rst_vld", 32'(o_inst_vld), 32'd1);
    i_reset = 1'b1;
    run_cycle();
    check("mid_rst_inst_vld", 32'(o_inst_vld), 32'd0);
    check("mid_rst_req_vld", 32'(o_imem_req_vld), 32'd0);
    check("mid_rst_inst", o_inst, 32'h0);
    i_reset = 1'b0;
    i_inst_rdy = 1'b1;
    #1;
    check("restart_req_vld", 32'(o_imem_req_vld), 32'd1);
    check("restart_addr", o_imem_addr, RESET_PC);
    repeat (12) run_cycle();

    // Drain: every issued word must have been delivered
    i_imem_req_rdy = 1'b0;
    repeat (6) run_cycle();
    check("drained", 32'(exp_q.size()), 32'd0);
    check("pops_seen", 32'(n_pops >= 40), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
